// File: rtl/cpu_timer_multi.sv
// cpu_timer_multi: NUM_CH independent Avalon-MM interval timers with 8-bit
// prescalers, one-shot/continuous modes, count snapshots and maskable
// timeout interrupts. Each channel occupies four word addresses:
// STATUS, CONTROL, PERIOD, SNAPSHOT.
module cpu_timer_multi #(
  parameter int          NUM_CH         = 4,
  parameter int          CNT_W          = 32,
  parameter int          DATA_W         = 32,
  parameter int unsigned DEFAULT_PERIOD = 49999,
  parameter int          ADDR_W         = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic [NUM_CH-1:0] irq_vec,
  output logic              irq
);

  localparam logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(DEFAULT_PERIOD);

  logic              wr_en;
  logic [ADDR_W-1:0] ch_num;
  logic [1:0]        reg_sel;
  logic [DATA_W-1:0] rd_next;
  logic              unused_wdata;

  // Per-channel state exported for the read mux and interrupt logic
  logic             ch_to       [NUM_CH];
  logic             ch_run      [NUM_CH];
  logic             ch_ito      [NUM_CH];
  logic             ch_cont     [NUM_CH];
  logic [7:0]       ch_prescale [NUM_CH];
  logic [CNT_W-1:0] ch_period   [NUM_CH];
  logic [CNT_W-1:0] ch_snap     [NUM_CH];

  assign wr_en        = chipselect & ~write_n;
  assign ch_num       = address >> 2;
  assign reg_sel      = address[1:0];
  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic             sel, wr_status, wr_ctrl, wr_period, wr_snap;
    logic             start, stop, tick, expire;
    logic [CNT_W-1:0] count_q, period_q, snap_q;
    logic [7:0]       presc_q, prescale_q;
    logic             to_q, run_q, ito_q, cont_q, reload_q;

    assign sel       = wr_en & (ch_num == ADDR_W'(i));
    assign wr_status = sel & (reg_sel == 2'd0);
    assign wr_ctrl   = sel & (reg_sel == 2'd1);
    assign wr_period = sel & (reg_sel == 2'd2);
    assign wr_snap   = sel & (reg_sel == 2'd3);
    assign start     = wr_ctrl & writedata[2];
    assign stop      = wr_ctrl & writedata[3];
    assign tick      = run_q & (presc_q == prescale_q);
    assign expire    = tick & (count_q == '0);

    // Channel registers: prescaler, down-counter, reload, flags and snapshot
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        count_q    <= DEF_PERIOD;
        period_q   <= DEF_PERIOD;
        snap_q     <= '0;
        presc_q    <= '0;
        prescale_q <= '0;
        to_q       <= 1'b0;
        run_q      <= 1'b0;
        ito_q      <= 1'b0;
        cont_q     <= 1'b0;
        reload_q   <= 1'b0;
      end else begin
        // A presc value above a freshly lowered PRESCALE simply wraps
        // through 255 before it matches again.
        if (start || wr_period || tick)
          presc_q <= '0;
        else if (run_q)
          presc_q <= presc_q + 8'd1;

        // A PERIOD write stops the channel; the count picks up the new
        // period one edge later without raising TO.
        reload_q <= wr_period;
        if (reload_q)
          count_q <= period_q;
        else if (expire)
          count_q <= period_q;
        else if (tick)
          count_q <= count_q - CNT_W'(1);

        if (wr_period)
          period_q <= writedata[CNT_W-1:0];

        if (wr_ctrl) begin
          ito_q      <= writedata[0];
          cont_q     <= writedata[1];
          prescale_q <= writedata[15:8];
        end

        // Hardware set beats a software clear on the same edge
        if (expire)
          to_q <= 1'b1;
        else if (wr_status && writedata[0])
          to_q <= 1'b0;

        if (start)
          run_q <= 1'b1;
        else if (stop || wr_period)
          run_q <= 1'b0;
        else if (expire && !cont_q)
          run_q <= 1'b0;

        if (wr_snap)
          snap_q <= count_q;
      end
    end

    assign ch_to[i]       = to_q;
    assign ch_run[i]      = run_q;
    assign ch_ito[i]      = ito_q;
    assign ch_cont[i]     = cont_q;
    assign ch_prescale[i] = prescale_q;
    assign ch_period[i]   = period_q;
    assign ch_snap[i]     = snap_q;
  end

  // Read mux; unimplemented channel indices return zero
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_num == ADDR_W'(i)) begin
        case (reg_sel)
          2'd0:    rd_next = DATA_W'({ch_run[i], ch_to[i]});
          2'd1:    rd_next = DATA_W'({ch_prescale[i], 6'b0, ch_cont[i], ch_ito[i]});
          2'd2:    rd_next = DATA_W'(ch_period[i]);
          default: rd_next = DATA_W'(ch_snap[i]);
        endcase
      end
    end
  end

  // Registered read data: address is sampled every cycle, one-cycle latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      readdata <= '0;
    else
      readdata <= rd_next;
  end

  // Interrupts are the registered TO flags gated by their enables
  always_comb begin
    irq_vec = '0;
    for (int i = 0; i < NUM_CH; i++)
      irq_vec[i] = ch_to[i] & ch_ito[i];
    irq = |irq_vec;
  end

endmodule

// File: tb/tb_cpu_timer_multi.sv
// Self-checking bench for cpu_timer_multi. Five channels are instantiated
// so that channel index NUM_CH (5) is addressable and must read as zero.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_cpu_timer_multi;

  localparam int NUM_CH = 5;
  localparam int CNT_W  = 32;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              reset;
  logic              chipselect;
  logic              write_n;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic [NUM_CH-1:0] irq_vec;
  logic              irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  cpu_timer_multi #(
    .NUM_CH(NUM_CH),
    .CNT_W(CNT_W),
    .DATA_W(DATA_W),
    .DEFAULT_PERIOD(49999)
  ) dut (
    .clk(clk),
    .reset(reset),
    .chipselect(chipselect),
    .write_n(write_n),
    .address(address),
    .writedata(writedata),
    .readdata(readdata),
    .irq_vec(irq_vec),
    .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One-cycle Avalon write, sampled on the next rising edge
  task automatic wr(input int ch, input int r, input logic [31:0] d);
    address    = ADDR_W'(ch * 4 + r);
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Present an address; readdata is valid after the next rising edge
  task automatic rd(input int ch, input int r, output logic [31:0] d);
    address = ADDR_W'(ch * 4 + r);
    @(negedge clk);
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] got, e;
    repeat (2) @(negedge clk);
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); checks++;
    if (readdata !== e || {irq, irq_vec} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: readdata=%h irq=%b irq_vec=%b, expected all zero", readdata, irq, irq_vec);
    end
    reset = 1'b0;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'd49999); exp_q.push_back(32'd0);
    for (int r = 0; r < 4; r++) begin
      rd(0, r, got);
      e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_ch0_reg%0d: got %0d expected %0d", r, got, e);
      end
    end
  endtask

  task automatic test_continuous_ch1();
    logic [31:0] e;
    wr(1, 2, 32'd4);
    wr(1, 1, 32'h0007);
    for (int k = 1; k <= 5; k++) begin
      exp_q.push_back((k == 5) ? 32'h22 : 32'h0);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({26'b0, irq, irq_vec} !== e) begin
        errors++;
        $display("FAIL cont_ch1_first k=%0d: irq/vec=%b expected %b", k, {irq, irq_vec}, e[5:0]);
      end
    end
    exp_q.push_back(32'h0);
    wr(1, 0, 32'h1);
    e = exp_q.pop_front(); checks++;
    if ({26'b0, irq, irq_vec} !== e) begin
      errors++;
      $display("FAIL cont_ch1_clear: irq/vec=%b expected %b", {irq, irq_vec}, e[5:0]);
    end
    for (int k = 7; k <= 10; k++) begin
      exp_q.push_back((k == 10) ? 32'h22 : 32'h0);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({26'b0, irq, irq_vec} !== e) begin
        errors++;
        $display("FAIL cont_ch1_second k=%0d: irq/vec=%b expected %b", k, {irq, irq_vec}, e[5:0]);
      end
    end
    wr(1, 1, 32'h0008);
    exp_q.push_back(32'h0);
    wr(1, 0, 32'h1);
    e = exp_q.pop_front(); checks++;
    if ({26'b0, irq, irq_vec} !== e) begin
      errors++;
      $display("FAIL cont_ch1_stop: irq/vec=%b expected %b", {irq, irq_vec}, e[5:0]);
    end
  endtask

  task automatic test_oneshot_prescale_ch2();
    logic [31:0] got, e;
    wr(2, 2, 32'd2);
    wr(2, 1, 32'h0305);
    for (int k = 1; k <= 13; k++) begin
      exp_q.push_back((k >= 12) ? 32'h24 : 32'h0);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({26'b0, irq, irq_vec} !== e) begin
        errors++;
        $display("FAIL oneshot_ch2 k=%0d: irq/vec=%b expected %b", k, {irq, irq_vec}, e[5:0]);
      end
    end
    exp_q.push_back(32'h1);
    rd(2, 0, got);
    e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL oneshot_ch2_status: got %h expected %h", got, e);
    end
    wr(2, 3, 32'h0);
    exp_q.push_back(32'd2);
    rd(2, 3, got);
    e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL oneshot_ch2_reload: got %0d expected %0d", got, e);
    end
    wr(2, 0, 32'h1);
    for (int k = 0; k < 50; k++) begin
      exp_q.push_back(32'h0);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({26'b0, irq, irq_vec} !== e) begin
        errors++;
        $display("FAIL oneshot_ch2_quiet k=%0d: irq/vec=%b expected %b", k, {irq, irq_vec}, e[5:0]);
      end
    end
    wr(2, 1, 32'h0300);
  endtask

  task automatic test_period_write_ch0();
    logic [31:0] got, e;
    wr(0, 2, 32'd100);
    wr(0, 1, 32'h0004);
    repeat (10) @(negedge clk);
    wr(0, 2, 32'd10);
    exp_q.push_back(32'h0);
    rd(0, 0, got);
    e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL period_write_run: status %h expected %h", got, e);
    end
    wr(0, 3, 32'h0);
    exp_q.push_back(32'd10);
    rd(0, 3, got);
    e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL period_write_reload: count %0d expected %0d", got, e);
    end
    wr(0, 1, 32'h0007);
    for (int k = 1; k <= 11; k++) begin
      exp_q.push_back((k == 11) ? 32'h21 : 32'h0);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({26'b0, irq, irq_vec} !== e) begin
        errors++;
        $display("FAIL cont_ch0_first k=%0d: irq/vec=%b expected %b", k, {irq, irq_vec}, e[5:0]);
      end
    end
    wr(0, 0, 32'h1);
    for (int k = 12; k <= 20; k++) begin
      exp_q.push_back(32'h0);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if ({26'b0, irq, irq_vec} !== e) begin
        errors++;
        $display("FAIL cont_ch0_gap k=%0d: irq/vec=%b expected %b", k, {irq, irq_vec}, e[5:0]);
      end
    end
    // The clear lands on the same edge as the second timeout
    exp_q.push_back(32'h21);
    wr(0, 0, 32'h1);
    e = exp_q.pop_front(); checks++;
    if ({26'b0, irq, irq_vec} !== e) begin
      errors++;
      $display("FAIL to_set_vs_clear: irq/vec=%b expected %b", {irq, irq_vec}, e[5:0]);
    end
    exp_q.push_back(32'h3);
    rd(0, 0, got);
    e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL to_set_vs_clear_status: got %h expected %h", got, e);
    end
    wr(0, 1, 32'h0008);
    exp_q.push_back(32'h0);
    wr(0, 0, 32'h1);
    e = exp_q.pop_front(); checks++;
    if ({26'b0, irq, irq_vec} !== e) begin
      errors++;
      $display("FAIL cont_ch0_stop: irq/vec=%b expected %b", {irq, irq_vec}, e[5:0]);
    end
  endtask

  task automatic test_snapshot_ch3();
    logic [31:0] got, e;
    wr(3, 2, 32'd1000);
    wr(3, 1, 32'h0004);
    repeat (19) @(negedge clk);
    wr(3, 3, 32'h0);
    exp_q.push_back(32'd981);
    rd(3, 3, got);
    e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL snapshot_ch3: got %0d expected %0d", got, e);
    end
    wr(3, 1, 32'h0008);
    exp_q.push_back(32'h0);
    rd(3, 0, got);
    e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL stop_ch3: status %h expected %h", got, e);
    end
    wr(3, 1, 32'h000C);
    exp_q.push_back(32'h2);
    exp_q.push_back(32'h0);
    for (int r = 0; r < 2; r++) begin
      rd(3, r, got);
      e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL start_wins_reg%0d: got %h expected %h", r, got, e);
      end
    end
    wr(3, 1, 32'hFFFF_FFF3);
    exp_q.push_back(32'h0000_FF03);
    rd(3, 1, got);
    e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL control_readback: got %h expected %h", got, e);
    end
    wr(3, 1, 32'h0008);
  endtask

  task automatic test_invalid_channel();
    logic [31:0] got, e;
    int ch_l[8];
    int rg_l[8];
    ch_l = '{5, 5, 5, 5, 6, 7, 0, 1};
    rg_l = '{0, 1, 2, 3, 2, 2, 2, 2};
    wr(5, 2, 32'd7);
    wr(5, 1, 32'h0007);
    wr(7, 2, 32'd9);
    wr(5, 3, 32'h0);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'd10); exp_q.push_back(32'd4);
    for (int n = 0; n < 8; n++) begin
      rd(ch_l[n], rg_l[n], got);
      e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL invalid_ch_read ch%0d reg%0d: got %0d expected %0d", ch_l[n], rg_l[n], got, e);
      end
    end
    repeat (12) @(negedge clk);
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); checks++;
    if ({26'b0, irq, irq_vec} !== e) begin
      errors++;
      $display("FAIL invalid_ch_irq: irq/vec=%b expected %b", {irq, irq_vec}, e[5:0]);
    end
  endtask

  task automatic test_reset_midcount();
    logic [31:0] got, e;
    wr(1, 2, 32'd4);
    wr(1, 1, 32'h0007);
    repeat (6) @(negedge clk);
    exp_q.push_back(32'h22);
    e = exp_q.pop_front(); checks++;
    if ({26'b0, irq, irq_vec} !== e) begin
      errors++;
      $display("FAIL midcount_pre_irq: irq/vec=%b expected %b", {irq, irq_vec}, e[5:0]);
    end
    exp_q.push_back(32'd4);
    rd(1, 2, got);
    e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL midcount_pre_read: got %0d expected %0d", got, e);
    end
    #2 reset = 1'b1;
    #1;
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); checks++;
    if (readdata !== e || {irq, irq_vec} !== 6'b0) begin
      errors++;
      $display("FAIL midcount_async_reset: readdata=%h irq/vec=%b expected zero", readdata, {irq, irq_vec});
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(32'd49999); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    for (int r = 2; r >= 0; r--) begin
      rd(1, r, got);
      e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL midcount_after_reg%0d: got %0d expected %0d", r, got, e);
      end
    end
    repeat (10) @(negedge clk);
    exp_q.push_back(32'h0);
    rd(1, 0, got);
    e = exp_q.pop_front(); checks++;
    if (got !== e || {irq, irq_vec} !== 6'b0) begin
      errors++;
      $display("FAIL midcount_idle: status %h irq/vec=%b expected %h and zero", got, {irq, irq_vec}, e);
    end
  endtask

  initial begin
    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = '0;
    writedata  = '0;
    test_reset();
    test_continuous_ch1();
    test_oneshot_prescale_ch2();
    test_period_write_ch0();
    test_snapshot_ch3();
    test_invalid_channel();
    test_reset_midcount();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
